// File: rtl/info_frame_builder_if.sv
// rtl/info_frame_builder_if.sv - staging-write, commit/swap and packet output bundle for the InfoFrame builder
interface info_frame_builder_if;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             commit;
  logic             swap;
  logic             busy;
  logic             pending;
  logic             drop;
  logic             valid;
  logic [23:0]      header;
  logic [3:0][55:0] sub;

  modport master (
    output wr_en, wr_addr, wr_data, commit, swap,
    input  busy, pending, drop, valid, header, sub
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, swap,
    output busy, pending, drop, valid, header, sub
  );
endinterface

// File: rtl/info_frame_builder.sv
// rtl/info_frame_builder.sv - double-buffered programmable InfoFrame source with sequential checksum
module info_frame_builder #(
  parameter logic [6:0] INFO_FRAME_TYPE = 7'd2,
  parameter logic [7:0] VERSION         = 8'd2,
  parameter logic [4:0] LENGTH          = 5'd13
) (
  input logic               clk_pixel,
  input logic               reset,
  info_frame_builder_if.slave bus
);

  localparam int LEN = int'(LENGTH);
  localparam logic [23:0] HEADER  = {3'b000, LENGTH, VERSION, 1'b1, INFO_FRAME_TYPE};
  localparam logic [7:0]  HDR_SUM = 8'(HEADER[7:0] + HEADER[15:8] + HEADER[23:16]);

  if (LENGTH < 5'd1 || LENGTH > 5'd27) begin : g_bad_length
    $error("info_frame_builder: LENGTH must be in 1..27");
  end

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_PENDING} state_e;

  state_e           state_q;
  logic [4:0]       idx_q;
  logic [7:0]       acc_q;
  logic [LEN:1][7:0] stg_q;
  logic [27:0][7:0] act_q;
  logic             busy_q;
  logic             pending_q;
  logic             drop_q;
  logic             valid_q;
  logic [7:0]       stg_sel;
  logic             wr_legal;

  assign wr_legal = (bus.wr_addr >= 5'd1) && (bus.wr_addr <= LENGTH);

  always_comb begin
    stg_sel = 8'h00;
    for (int i = 1; i <= LEN; i++) begin
      if (idx_q == 5'(i)) stg_sel = stg_q[i];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      acc_q     <= 8'h00;
      stg_q     <= '0;
      act_q     <= '0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A write coinciding with commit lands before SUM starts reading.
          if (bus.wr_en) begin
            if (wr_legal) begin
              for (int i = 1; i <= LEN; i++) begin
                if (bus.wr_addr == 5'(i)) stg_q[i] <= bus.wr_data;
              end
            end else begin
              drop_q <= 1'b1;
            end
          end
          if (bus.commit) begin
            state_q <= S_SUM;
            idx_q   <= 5'd1;
            acc_q   <= HDR_SUM;
            busy_q  <= 1'b1;
          end
        end
        S_SUM: begin
          drop_q <= bus.wr_en;
          acc_q  <= acc_q + stg_sel;
          idx_q  <= idx_q + 5'd1;
          if (idx_q == LENGTH) begin
            state_q   <= S_PENDING;
            pending_q <= 1'b1;
          end
        end
        S_PENDING: begin
          drop_q <= bus.wr_en;
          if (bus.swap) begin
            act_q[0] <= 8'h00 - acc_q;
            for (int i = 1; i <= LEN; i++) act_q[i] <= stg_q[i];
            for (int i = LEN + 1; i <= 27; i++) act_q[i] <= 8'h00;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.header  = HEADER;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;
  assign bus.drop    = drop_q;
  assign bus.valid   = valid_q;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    assign bus.sub[g] = act_q[7*g+6 -: 7];
  end

endmodule

// File: tb/tb_info_frame_builder.sv
// tb/tb_info_frame_builder.sv - directed bench for info_frame_builder at LENGTH 13, 27 and 1
module tb_info_frame_builder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'h00;
  logic       commit = 1'b0;
  logic       swap = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         n;
  logic       ok;

  localparam logic [3:0][55:0] PKT_A = {168'h0, 56'h0000100000005F};

  info_frame_builder_if bus_d ();
  info_frame_builder_if bus_l ();
  info_frame_builder_if bus_s ();

  assign bus_d.wr_en = wr_en;  assign bus_l.wr_en = wr_en;  assign bus_s.wr_en = wr_en;
  assign bus_d.wr_addr = wr_addr;  assign bus_l.wr_addr = wr_addr;  assign bus_s.wr_addr = wr_addr;
  assign bus_d.wr_data = wr_data;  assign bus_l.wr_data = wr_data;  assign bus_s.wr_data = wr_data;
  assign bus_d.commit = commit;  assign bus_l.commit = commit;  assign bus_s.commit = commit;
  assign bus_d.swap = swap;  assign bus_l.swap = swap;  assign bus_s.swap = swap;

  info_frame_builder u_dut (.clk_pixel(clk), .reset(reset), .bus(bus_d));
  info_frame_builder #(.LENGTH(5'd27)) u_dut_l (.clk_pixel(clk), .reset(reset), .bus(bus_l));
  info_frame_builder #(.LENGTH(5'd1)) u_dut_s (.clk_pixel(clk), .reset(reset), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1; step(); commit = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1; step(); swap = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    check("rst_valid", 64'(bus_d.valid), 64'd0);
    check("rst_busy", 64'(bus_d.busy), 64'd0);
    check("rst_pending", 64'(bus_d.pending), 64'd0);
    check("rst_sub_zero", 64'(bus_d.sub == '0), 64'd1);
    check("rst_header", 64'(bus_d.header), 64'h0D0282);
    check("rst_header_l", 64'(bus_l.header), 64'h1B0282);
    check("rst_header_s", 64'(bus_s.header), 64'h010282);

    // AVI VIC 16
    wr(5'd4, 8'h10);
    check("legal_no_drop", 64'(bus_d.drop), 64'd0);
    pulse_commit();
    check("commit_busy", 64'(bus_d.busy), 64'd1);
    n = 0;
    while (!bus_d.pending && n < 40) begin step(); n++; end
    check("pend_latency", 64'(n), 64'd13);
    check("l_still_sum", 64'({bus_l.busy, bus_l.pending}), 64'b10);
    pulse_swap();
    check("avi_pb0", 64'(bus_d.sub[0][7:0]), 64'h5F);
    check("avi_pb4", 64'(bus_d.sub[0][39:32]), 64'h10);
    check("avi_valid", 64'(bus_d.valid), 64'd1);
    check("avi_idle", 64'({bus_d.busy, bus_d.pending}), 64'd0);
    check("s_pkt1", 64'(bus_s.sub[0]), 64'h7B);
    check("l_swap_lost", 64'(bus_l.valid), 64'd0);
    n = 0;
    while (!bus_l.pending && n < 40) begin step(); n++; end
    check("l_pending", 64'(bus_l.pending), 64'd1);
    pulse_swap();
    check("l_pkt1", 64'(bus_l.sub[0]), 64'h00001000000051);
    check("idle_swap_ignored", 64'(bus_d.sub == PKT_A), 64'd1);

    // rejected writes
    wr(5'd0, 8'hAA);
    check("drop_addr0", 64'(bus_d.drop), 64'd1);
    wr(5'd14, 8'h55);
    check("drop_addr14", 64'(bus_d.drop), 64'd1);
    check("l_addr14_ok", 64'(bus_l.drop), 64'd0);
    step();
    check("drop_one_cycle", 64'(bus_d.drop), 64'd0);
    wr(5'd1, 8'h01);
    pulse_commit();
    wr(5'd2, 8'h77);
    check("drop_in_sum", 64'(bus_d.drop), 64'd1);
    pulse_swap();
    check("sum_swap_sub", 64'(bus_d.sub == PKT_A), 64'd1);
    check("sum_swap_state", 64'({bus_d.busy, bus_d.pending}), 64'b10);

    // double buffering
    n = 0;
    while (!bus_d.pending && n < 40) begin step(); n++; end
    check("b_pending", 64'(bus_d.pending), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus_d.sub !== PKT_A || bus_d.pending !== 1'b1) ok = 1'b0;
    end
    check("hold_stable", 64'(ok), 64'd1);
    pulse_swap();
    check("b_sub0", 64'(bus_d.sub[0]), 64'h0000100000015E);
    check("l_pkt2", 64'(bus_l.sub[0]), 64'h000010000001FB);
    check("l_pb14", 64'(bus_l.sub[2][7:0]), 64'h55);
    check("s_pkt2", 64'(bus_s.sub[0]), 64'h017A);

    // reset while pending
    wr(5'd5, 8'h22);
    pulse_commit();
    n = 0;
    while (!bus_l.pending && n < 40) begin step(); n++; end
    check("pre_rst_pend", 64'({bus_d.pending, bus_l.pending, bus_s.pending}), 64'b111);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_state", 64'({bus_d.busy, bus_d.pending, bus_d.valid}), 64'd0);
    check("mid_rst_sub", 64'(bus_d.sub == '0), 64'd1);
    check("mid_rst_l", 64'({bus_l.busy, bus_l.pending, bus_l.valid, bus_l.sub == '0}), 64'b0001);
    check("mid_rst_s", 64'({bus_s.busy, bus_s.pending, bus_s.valid, bus_s.sub == '0}), 64'b0001);

    // checksum boundary lengths
    wr(5'd27, 8'h3C);
    wr(5'd1, 8'hFF);
    pulse_commit();
    n = 0;
    while (!bus_l.pending && n < 40) begin step(); n++; end
    check("bnd_pending", 64'({bus_d.pending, bus_l.pending, bus_s.pending}), 64'b111);
    pulse_swap();
    check("l_pb27", 64'(bus_l.sub[3][55:48]), 64'h3C);
    check("l_pb1_pb0", 64'(bus_l.sub[0][15:0]), 64'hFF26);
    check("s_pb1_pb0", 64'(bus_s.sub[0]), 64'hFF7C);
    check("d_pb1_pb0", 64'(bus_d.sub[0]), 64'hFF70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
